// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues one request at a
// time to instruction memory and presents the fetched word to IF/ID.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   stallF                   hold the presented instruction (IF/ID not capturing)
//   redirect, redirect_pc    taken branch/jump from decode and its target
//   imem_req, imem_addr      request pulse and address to instruction memory
//   imem_rvalid, imem_rdata  response strobe and instruction word
//   instrF, pc_plus4F        instruction and PC+4 for IF/ID (0 when not valid)
//   fetch_wait               no valid instruction presented
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrF,
  output logic [31:0] pc_plus4F,
  output logic        fetch_wait
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned SW   = 3;

  localparam logic [SW-1:0] S_IDLE  = 3'd0;
  localparam logic [SW-1:0] S_ISSUE = 3'd1;
  localparam logic [SW-1:0] S_WAIT  = 3'd2;
  localparam logic [SW-1:0] S_VALID = 3'd3;
  localparam logic [SW-1:0] S_DROP  = 3'd4;

  logic [SW-1:0]   state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [XLEN-1:0] ibuf, ibuf_n;
  logic [XLEN-1:0] tgt;

  // Redirect target forced to word alignment.
  assign tgt = redirect_pc & ~XLEN'(3);

  // Next-state, next-PC and buffer logic; redirect overrides the normal rule.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ibuf_n  = ibuf;
    case (state)
      S_IDLE: state_n = S_ISSUE;
      S_ISSUE: begin
        if (redirect) begin
          pc_n    = tgt;
          state_n = S_DROP;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response coincident with a redirect belongs to the old path.
        if (redirect) begin
          pc_n    = tgt;
          state_n = S_DROP;
        end else if (imem_rvalid) begin
          ibuf_n  = imem_rdata;
          state_n = S_VALID;
        end
      end
      S_VALID: begin
        if (redirect) begin
          pc_n    = tgt;
          ibuf_n  = '0;
          state_n = S_ISSUE;
        end else if (!stallF) begin
          pc_n    = pc + XLEN'(4);
          state_n = S_ISSUE;
        end
      end
      S_DROP: begin
        // Latest redirect target wins while the stale response drains.
        if (redirect) pc_n = tgt;
        if (imem_rvalid) state_n = S_ISSUE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, PC, buffer and outputs; outputs are registered from next values
  // so they always reflect the current state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      ibuf       <= '0;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      instrF     <= '0;
      pc_plus4F  <= '0;
      fetch_wait <= 1'b1;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      ibuf       <= ibuf_n;
      imem_req   <= (state_n == S_ISSUE);
      imem_addr  <= pc_n;
      instrF     <= (state_n == S_VALID) ? ibuf_n : '0;
      pc_plus4F  <= (state_n == S_VALID) ? (pc_n + XLEN'(4)) : '0;
      fetch_wait <= (state_n != S_VALID);
    end
  end

endmodule
